fifo_read_streamer: RTL
=======================

FIFO_READ_STREAMER -- requirements
Module: fifo_read_streamer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of FIFO read data and stream data.
REQ-002 Parameter CNT_WIDTH, default 16, width of delivered-word counter.
REQ-003 rclk  input  1  read-domain clock; all state changes on its rising edge.
REQ-004 rrst_n  input  1  reset, asynchronous, active-low.
REQ-005 rempty  input  1  FIFO read-side empty flag.
REQ-006 rdata  input  DATA_WIDTH  FIFO read data, valid in the cycle after rinc was high.
REQ-007 rinc  output  1  FIFO read increment (pop request).
REQ-008 rd_en  input  1  enables issuing new rinc.
REQ-009 flush  input  1  single-cycle request to discard all buffered and in-flight words.
REQ-010 m_valid  output  1  stream word valid.
REQ-011 m_data  output  DATA_WIDTH  stream word.
REQ-012 m_ready  input  1  downstream accept.
REQ-013 words_out  output  CNT_WIDTH  count of words delivered (m_valid && m_ready).
REQ-014 busy  output  1  high when occupancy or in-flight is nonzero, or in FLUSH.

Function
REQ-015 Internal 2-entry buffer; occ in 0..2; inflight = registered copy of rinc.
REQ-016 pop = m_valid && m_ready; words accepted in FIFO order, no duplication or loss outside flush.
REQ-017 State RUN: rinc = rd_en && !rempty && ((occ + inflight) < 2 || pop).
REQ-018 Invariant: occ + inflight never exceeds 2; rinc never high while rempty high.
REQ-019 When inflight is 1, rdata is written to the buffer tail at that rising edge; occ_next = occ + inflight - pop.
REQ-020 m_valid = (occ != 0) in RUN; m_data = buffer head, registered, stable while m_valid && !m_ready.
REQ-021 Latency: rempty falls in cycle 0 with buffer empty, rd_en=1 -> rinc in cycle 0, rdata in cycle 1, m_valid in cycle 2.
REQ-022 Throughput: with rempty=0, rd_en=1, m_ready=1 held, one word per cycle is sustained indefinitely.
REQ-023 Backpressure: m_ready=0 stops rinc once occ + inflight = 2; no word is dropped.
REQ-024 rd_en falling stops new rinc only; buffered and in-flight words still drain.
REQ-025 flush in RUN -> state FLUSH next cycle; occ cleared, m_valid=0, rinc=0 in FLUSH.
REQ-026 In FLUSH, a landing in-flight word is discarded; return to RUN when inflight=0 (FLUSH lasts exactly 1 or 2 cycles).
REQ-027 pop and flush in the same cycle: the popped word counts as delivered, everything else discarded.
REQ-028 flush while in FLUSH is ignored.
REQ-029 words_out increments by 1 per pop and wraps modulo 2^CNT_WIDTH; flush does not clear it.

Reset
REQ-030 rrst_n low asynchronously forces state RUN, occ=0, inflight=0, rinc=0, m_valid=0, m_data=0, words_out=0, busy=0.
REQ-031 A reset asserted mid-stream discards buffered and in-flight words; the first rinc after release follows REQ-017.
REQ-032 Reset deassertion is synchronized externally to rclk.

Structure
REQ-033 State enum (RUN, FLUSH) and default DATA_WIDTH/CNT_WIDTH constants shall live in shared package fifo_rtl_pkg.
REQ-034 The 2-entry buffer shall be a sub-module rd_skid_buf (push, pop, din, dout, occ).
REQ-035 No combinational path from rdata to any output.

Verification
REQ-036 Reset, then FIFO preloaded 0x11,0x22,0x33; rd_en=1, m_ready=1 -> m_data 0x11,0x22,0x33 on three consecutive cycles starting cycle 2; words_out=3.
REQ-037 Preload 5 words, m_ready=0 for 10 cycles -> exactly 2 rinc pulses, m_valid=1 holding word 0; release m_ready -> all 5 delivered in order.
REQ-038 Stream running with occ=1, inflight=1, pulse flush -> m_valid=0 for 2 cycles, in-flight word never appears on m_data, words_out unchanged; streaming resumes with the next FIFO word.
REQ-039 Preload 3 words, rempty stays 0 for one word only, toggling rempty every cycle -> rinc never high with rempty high; no loss.
REQ-040 words_out preset near 0xFFFF via 0xFFFF+2 pops -> reads 0x0001.
REQ-041 Assert rrst_n low asynchronously between clock edges during streaming -> outputs at reset values immediately, no spurious rinc after release with rd_en=0.

Source files
------------

// File: rtl/fifo_rtl_pkg.sv
// Shared constants and state type for the FIFO read streamer.
// The defaults match the common 8-bit data, 16-bit counter build.
package fifo_rtl_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } rd_state_e;

endpackage

// File: rtl/fifo_read_streamer_if.sv
// Downstream valid/ready stream carrying words read from the FIFO.
// master drives valid/data, slave drives ready.
interface fifo_read_streamer_if
  import fifo_rtl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF
);

  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    output m_ready
  );

endinterface

// File: rtl/rd_skid_buf.sv
// Two-entry in-order buffer; head is a register so dout never
// depends combinationally on din.
module rd_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   occ
);

  logic [W-1:0] tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
      tail <= '0;
      occ  <= 2'd0;
    end else if (clr) begin
      occ <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) dout <= din;
          else             tail <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          dout <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // Full buffer shifts tail up; single entry is replaced.
          if (occ == 2'd2) begin
            dout <= tail;
            tail <= din;
          end else begin
            dout <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_read_streamer.sv
// Pops an async-FIFO read port into a valid/ready stream with
// a 2-entry skid buffer, flush support and a delivered-word count.
module fifo_read_streamer
  import fifo_rtl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int CNT_WIDTH  = CNT_W_DEF
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  input  logic                  rd_en,
  input  logic                  flush,
  fifo_read_streamer_if.master  m,
  output logic [CNT_WIDTH-1:0]  words_out,
  output logic                  busy
);

  rd_state_e state, state_nxt;
  logic       inflight;
  logic [1:0] occ;
  logic       in_run;
  logic       room;
  logic       pop;
  logic       push;
  logic       clr;
  logic [DATA_WIDTH-1:0] head;

  assign in_run    = (state == RUN);
  assign m.m_valid = in_run && (occ != 2'd0);
  assign m.m_data  = head;
  assign pop       = m.m_valid && m.m_ready;
  assign room      = ({1'b0, occ} + {2'b00, inflight}) < 3'd2;

  always_comb begin
    state_nxt = state;
    rinc      = 1'b0;
    push      = 1'b0;
    clr       = 1'b0;
    unique case (state)
      RUN: begin
        // rrst_n term keeps rinc low while reset is held.
        rinc = rrst_n && rd_en && !rempty && (room || pop);
        push = inflight && !flush;
        clr  = flush;
        if (flush) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (!inflight) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state     <= RUN;
      inflight  <= 1'b0;
      words_out <= '0;
    end else begin
      state     <= state_nxt;
      inflight  <= rinc;
      words_out <= words_out + CNT_WIDTH'(pop);
    end
  end

  assign busy = (occ != 2'd0) || inflight || (state == FLUSH);

  rd_skid_buf #(
    .W (DATA_WIDTH)
  ) u_buf (
    .clk   (rclk),
    .rst_n (rrst_n),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (rdata),
    .dout  (head),
    .occ   (occ)
  );

endmodule
